// File: rtl/udma_lin_tx_sequencer_if.sv
// rtl/udma_lin_tx_sequencer_if.sv - L2 read request bus between TX sequencer and L2 arbiter
interface udma_lin_tx_sequencer_if #(
    parameter int L2_AWIDTH_NOAL = 21,
    parameter int DEST_SIZE      = 2
);
    logic                      req;
    logic                      gnt;
    logic [L2_AWIDTH_NOAL-1:0] addr;
    logic [1:0]                datasize;
    logic [DEST_SIZE-1:0]      dest;

    modport master (output req, output addr, output datasize, output dest, input gnt);
    modport slave  (input req, input addr, input datasize, input dest, output gnt);
endinterface

// File: rtl/udma_lin_tx_sequencer.sv
// rtl/udma_lin_tx_sequencer.sv - linear uDMA TX channel sequencer with pending slot and auto-reload
module udma_lin_tx_sequencer #(
    parameter int TRANS_SIZE     = 20,
    parameter int L2_AWIDTH_NOAL = 21,
    parameter int DEST_SIZE      = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [DEST_SIZE-1:0]      cfg_dest_i,
    input  logic                      cfg_continuous_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    udma_lin_tx_sequencer_if.master   l2,
    output logic                      busy_o,
    output logic                      pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] curr_addr_o,
    output logic [TRANS_SIZE-1:0]     bytes_left_o,
    output logic                      evt_end_o
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q, state_d;
    logic [L2_AWIDTH_NOAL-1:0] addr_q, addr_d, sh_addr_q, sh_addr_d, pend_addr_q, pend_addr_d;
    logic [TRANS_SIZE-1:0]     left_q, left_d, sh_size_q, sh_size_d, pend_size_q, pend_size_d;
    logic [1:0]                ds_q, ds_d, sh_ds_q, sh_ds_d, pend_ds_q, pend_ds_d;
    logic [DEST_SIZE-1:0]      dest_q, dest_d, sh_dest_q, sh_dest_d, pend_dest_q, pend_dest_d;
    logic                      cont_q, cont_d, sh_cont_q, sh_cont_d, pend_cont_q, pend_cont_d;
    logic                      pend_valid_q, pend_valid_d;
    logic                      evt_q, evt_d;

    logic [2:0]                stride;
    logic [L2_AWIDTH_NOAL-1:0] stride_addr;
    logic [TRANS_SIZE-1:0]     stride_bytes;
    logic                      last_beat;
    logic                      cfg_ok;

    // State, active/shadow/pending configuration and event registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;  left_q      <= '0;  ds_q      <= '0;  dest_q      <= '0;  cont_q      <= 1'b0;
            sh_addr_q    <= '0;  sh_size_q   <= '0;  sh_ds_q   <= '0;  sh_dest_q   <= '0;  sh_cont_q   <= 1'b0;
            pend_addr_q  <= '0;  pend_size_q <= '0;  pend_ds_q <= '0;  pend_dest_q <= '0;  pend_cont_q <= 1'b0;
            pend_valid_q <= 1'b0;
            evt_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;       left_q      <= left_d;      ds_q      <= ds_d;
            dest_q       <= dest_d;       cont_q      <= cont_d;
            sh_addr_q    <= sh_addr_d;    sh_size_q   <= sh_size_d;   sh_ds_q   <= sh_ds_d;
            sh_dest_q    <= sh_dest_d;    sh_cont_q   <= sh_cont_d;
            pend_addr_q  <= pend_addr_d;  pend_size_q <= pend_size_d; pend_ds_q <= pend_ds_d;
            pend_dest_q  <= pend_dest_d;  pend_cont_q <= pend_cont_d;
            pend_valid_q <= pend_valid_d;
            evt_q        <= evt_d;
        end
    end

    // Next-state: start, queue, per-beat counting and end-of-transfer reload
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;       left_d      = left_q;      ds_d      = ds_q;
        dest_d       = dest_q;       cont_d      = cont_q;
        sh_addr_d    = sh_addr_q;    sh_size_d   = sh_size_q;   sh_ds_d   = sh_ds_q;
        sh_dest_d    = sh_dest_q;    sh_cont_d   = sh_cont_q;
        pend_addr_d  = pend_addr_q;  pend_size_d = pend_size_q; pend_ds_d = pend_ds_q;
        pend_dest_d  = pend_dest_q;  pend_cont_d = pend_cont_q;
        pend_valid_d = pend_valid_q;
        evt_d        = 1'b0;

        case (ds_q)
            2'd0:    stride = 3'd1;
            2'd1:    stride = 3'd2;
            default: stride = 3'd4;
        endcase
        stride_addr  = L2_AWIDTH_NOAL'(stride);
        stride_bytes = TRANS_SIZE'(stride);
        last_beat    = (left_q <= stride_bytes);
        cfg_ok       = cfg_en_i && (cfg_size_i != '0);

        if (cfg_clr_i) begin
            state_d      = IDLE;
            pend_valid_d = 1'b0;
            left_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_ok) begin
                        addr_d    = cfg_startaddr_i; left_d    = cfg_size_i;  ds_d    = cfg_datasize_i;
                        dest_d    = cfg_dest_i;      cont_d    = cfg_continuous_i;
                        sh_addr_d = cfg_startaddr_i; sh_size_d = cfg_size_i;  sh_ds_d = cfg_datasize_i;
                        sh_dest_d = cfg_dest_i;      sh_cont_d = cfg_continuous_i;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (cfg_ok && !pend_valid_q) begin
                        pend_addr_d  = cfg_startaddr_i; pend_size_d = cfg_size_i;
                        pend_ds_d    = cfg_datasize_i;  pend_dest_d = cfg_dest_i;
                        pend_cont_d  = cfg_continuous_i;
                        pend_valid_d = 1'b1;
                    end
                    if (l2.gnt) begin
                        addr_d = addr_q + stride_addr;
                        left_d = last_beat ? '0 : left_q - stride_bytes;
                        if (last_beat) begin
                            evt_d = 1'b1;
                            // A configuration queued in this same cycle counts as pending
                            if (pend_valid_d) begin
                                addr_d    = pend_addr_d; left_d    = pend_size_d; ds_d    = pend_ds_d;
                                dest_d    = pend_dest_d; cont_d    = pend_cont_d;
                                sh_addr_d = pend_addr_d; sh_size_d = pend_size_d; sh_ds_d = pend_ds_d;
                                sh_dest_d = pend_dest_d; sh_cont_d = pend_cont_d;
                                pend_valid_d = 1'b0;
                            end else if (cont_q) begin
                                addr_d = sh_addr_q; left_d = sh_size_q; ds_d = sh_ds_q;
                                dest_d = sh_dest_q; cont_d = sh_cont_q;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign l2.req       = (state_q == RUN);
    assign l2.addr      = addr_q;
    assign l2.datasize  = ds_q;
    assign l2.dest      = dest_q;
    assign busy_o       = (state_q == RUN);
    assign pending_o    = pend_valid_q;
    assign curr_addr_o  = addr_q;
    assign bytes_left_o = left_q;
    assign evt_end_o    = evt_q;
endmodule

// File: tb/tb_udma_lin_tx_sequencer.sv
// tb/tb_udma_lin_tx_sequencer.sv - randomized self-checking bench for udma_lin_tx_sequencer
module tb_udma_lin_tx_sequencer;
    localparam int TS = 20;
    localparam int AW = 21;
    localparam int DS = 2;
    localparam int unsigned AMASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cfg_start = '0;
    logic [TS-1:0] cfg_size = '0;
    logic [1:0]    cfg_ds = '0;
    logic [DS-1:0] cfg_dest = '0;
    logic          cfg_cont = 1'b0;
    logic          cfg_en = 1'b0;
    logic          cfg_clr = 1'b0;
    logic          busy, pending, evt;
    logic [AW-1:0] curr_addr;
    logic [TS-1:0] bytes_left;

    udma_lin_tx_sequencer_if #(.L2_AWIDTH_NOAL(AW), .DEST_SIZE(DS)) bus ();

    udma_lin_tx_sequencer #(.TRANS_SIZE(TS), .L2_AWIDTH_NOAL(AW), .DEST_SIZE(DS)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_startaddr_i(cfg_start), .cfg_size_i(cfg_size), .cfg_datasize_i(cfg_ds),
        .cfg_dest_i(cfg_dest), .cfg_continuous_i(cfg_cont), .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
        .l2(bus.master),
        .busy_o(busy), .pending_o(pending), .curr_addr_o(curr_addr),
        .bytes_left_o(bytes_left), .evt_end_o(evt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a running transfer, its reload copy and one queued transfer
    typedef struct {
        int unsigned addr, size, ds, dest;
        bit          cont;
    } xfer_t;

    bit          m_run, m_evt;
    int unsigned m_addr, m_left;
    xfer_t       m_cur, m_reload, m_queued;
    bit          m_has_queued;

    function automatic int unsigned bytes_per_beat(input int unsigned ds);
        return (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_evt = 0; m_addr = 0; m_left = 0; m_has_queued = 0;
        m_cur = '{0, 0, 0, 0, 0}; m_reload = m_cur; m_queued = m_cur;
    endfunction

    function automatic void model_begin(input xfer_t x);
        m_cur = x; m_reload = x; m_addr = x.addr; m_left = x.size; m_run = 1;
    endfunction

    function automatic void model_step();
        xfer_t       inx;
        int unsigned b;
        inx = '{int'(cfg_start), int'(cfg_size), int'(cfg_ds), int'(cfg_dest), cfg_cont};
        m_evt = 0;
        if (rst) begin
            model_reset();
        end else if (cfg_clr) begin
            m_run = 0; m_has_queued = 0; m_left = 0;
        end else if (!m_run) begin
            if (cfg_en && inx.size != 0) model_begin(inx);
        end else begin
            if (cfg_en && inx.size != 0 && !m_has_queued) begin
                m_queued = inx; m_has_queued = 1;
            end
            if (bus.gnt) begin
                b = bytes_per_beat(m_cur.ds);
                m_addr = (m_addr + b) & AMASK;
                if (m_left <= b) begin
                    m_left = 0;
                    m_evt  = 1;
                    if (m_has_queued) begin
                        m_has_queued = 0;
                        model_begin(m_queued);
                    end else if (m_cur.cont) begin
                        model_begin(m_reload);
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    m_left = m_left - b;
                end
            end
        end
    endfunction

    task automatic check_all();
        chk("req", 32'(bus.req), 32'(m_run));
        chk("busy", 32'(busy), 32'(m_run));
        chk("pending", 32'(pending), 32'(m_has_queued));
        chk("evt", 32'(evt), 32'(m_evt));
        chk("addr", 32'(bus.addr), m_addr);
        chk("curr_addr", 32'(curr_addr), m_addr);
        chk("bytes_left", 32'(bytes_left), m_left);
        chk("datasize", 32'(bus.datasize), m_cur.ds);
        chk("dest", 32'(bus.dest), m_cur.dest);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_cfg(input int unsigned a, input int unsigned s, input int unsigned d,
                           input int unsigned dst, input bit c);
        cfg_start = AW'(a); cfg_size = TS'(s); cfg_ds = 2'(d); cfg_dest = DS'(dst); cfg_cont = c;
    endtask

    int n_evt;

    initial begin
        model_reset();
        bus.gnt = 1'b0;
        #1;
        chk("reset_req", 32'(bus.req), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_evt", 32'(evt), 0);
        chk("reset_left", 32'(bytes_left), 0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // 1: two 4-byte beats, grant always high
        set_cfg('h100, 8, 2, 1, 0); cfg_en = 1; bus.gnt = 1;
        cycle(); cfg_en = 0;
        chk("t1_addr0", 32'(bus.addr), 'h100);
        cycle();
        chk("t1_addr1", 32'(bus.addr), 'h104);
        cycle();
        chk("t1_evt", 32'(evt), 1);
        chk("t1_busy", 32'(busy), 0);
        cycle();

        // 2: halfword beats, grant every third cycle
        set_cfg('h200, 6, 1, 2, 0); cfg_en = 1; bus.gnt = 0;
        cycle(); cfg_en = 0;
        n_evt = 0;
        for (int i = 0; i < 12; i++) begin
            bus.gnt = (i % 3 == 2);
            cycle();
            if (evt) n_evt++;
        end
        chk("t2_evt_count", 32'(n_evt), 1);
        bus.gnt = 0;

        // 3: queued configuration, no bubble, third enable ignored
        set_cfg('h500, 4, 2, 0, 0); cfg_en = 1;
        cycle();
        set_cfg('h300, 2, 0, 3, 0);
        cycle();
        chk("t3_pending", 32'(pending), 1);
        set_cfg('h600, 8, 2, 0, 0);
        cycle(); cfg_en = 0;
        bus.gnt = 1;
        cycle();
        chk("t3_end_evt", 32'(evt), 1);
        chk("t3_no_bubble", 32'(bus.req), 1);
        chk("t3_new_addr", 32'(bus.addr), 'h300);
        cycle();
        chk("t3_addr1", 32'(bus.addr), 'h301);
        cycle();
        chk("t3_idle", 32'(busy), 0);

        // 4: continuous bytes, then abort
        set_cfg('h40, 4, 0, 1, 1); cfg_en = 1;
        cycle(); cfg_en = 0;
        n_evt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (evt) n_evt++;
        end
        chk("t4_evt_count", 32'(n_evt), 3);
        chk("t4_wrap_addr", 32'(bus.addr), 'h40);
        cfg_clr = 1;
        cycle(); cfg_clr = 0;
        chk("t4_clr_busy", 32'(busy), 0);
        chk("t4_clr_evt", 32'(evt), 0);

        // 5: unaligned size saturates, zero size ignored
        set_cfg('h700, 5, 2, 0, 0); cfg_en = 1;
        cycle(); cfg_en = 0;
        cycle();
        chk("t5_left", 32'(bytes_left), 1);
        cycle();
        chk("t5_evt", 32'(evt), 1);
        chk("t5_left0", 32'(bytes_left), 0);
        set_cfg('h800, 0, 2, 0, 0); cfg_en = 1;
        cycle(); cfg_en = 0;
        chk("t5_size0_busy", 32'(busy), 0);

        // 6: asynchronous reset while running with a queued configuration
        bus.gnt = 0;
        set_cfg('h900, 16, 2, 2, 0); cfg_en = 1;
        cycle();
        set_cfg('hA00, 8, 1, 1, 0);
        cycle(); cfg_en = 0;
        chk("t6_pending", 32'(pending), 1);
        #2 rst = 1;
        #1;
        model_reset();
        chk("t6_rst_req", 32'(bus.req), 0);
        chk("t6_rst_pending", 32'(pending), 0);
        chk("t6_rst_addr", 32'(curr_addr), 0);
        check_all();
        cycle();
        rst = 0;
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cfg_en  = ($urandom_range(0, 5) == 0);
            cfg_clr = ($urandom_range(0, 70) == 0);
            bus.gnt = $urandom_range(0, 1);
            set_cfg(($urandom_range(0, 3) == 0) ? (AMASK - $urandom_range(0, 6)) : ($urandom & AMASK),
                    $urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0));
            cycle();
        end
        cfg_en = 0; cfg_clr = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
